// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: segment constants, digit segment table and scan FSM encoding.
package bcd_display_pkg;

    localparam logic [6:0] SEG_N_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_N_DASH = 7'b0111111;

    // Active-low gfedcba patterns for digits 0..9, index 0 first.
    localparam logic [0:9][6:0] SEG_TABLE = {
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_display_scan_if.sv
// bcd_display_scan_if: digit inputs and multiplexed 7-segment outputs of the scanner.
interface bcd_display_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_done;

    modport master (output digits_in, dp_in, input seg_n, dp_n, an_n, frame_done);
    modport slave  (input digits_in, dp_in, output seg_n, dp_n, an_n, frame_done);
endinterface

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to active-low gfedcba decoder, dash for codes 10..15.
module bcd_to_seg7
    import bcd_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);
    always_comb seg_n = (bcd > 4'd9) ? SEG_N_DASH : SEG_TABLE[bcd];
endmodule

// File: rtl/bcd_display_scan.sv
// bcd_display_scan: time-multiplexed common-anode 7-segment driver with per-frame snapshot.
// Define BCD_DISPLAY_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_display_scan
    import bcd_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input logic               clk,
    input logic               rst_n,
    bcd_display_scan_if.slave bus
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
    localparam logic [SW-1:0] S_LAST  = SW'(NUM_DIGITS - 1);

    logic [PW-1:0]           p, p_nxt;
    logic [SW-1:0]           slot, slot_nxt;
    state_t                  state, state_nxt;
    logic [4*NUM_DIGITS-1:0] snap, snap_nxt;
    logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_nxt;
    logic [3:0]              sel;
    logic [6:0]              dec, seg_nxt;
    logic                    drive;

    bcd_to_seg7 u_dec (.bcd(sel), .seg_n(dec));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_BLANK;
        else        state <= state_nxt;
    end

    // Outputs are decoded from next-cycle values, so the snapshot taken at
    // frame start is already visible when slot 0 enters DRIVE.
    always_comb begin
        p_nxt       = (p == P_LAST) ? '0 : p + 1'b1;
        slot_nxt    = (p != P_LAST) ? slot : (slot == S_LAST) ? '0 : slot + 1'b1;
        state_nxt   = state;
        if (state == ST_BLANK && p_nxt == P_BLANK) state_nxt = ST_DRIVE;
        if (state == ST_DRIVE && p_nxt == '0)      state_nxt = ST_BLANK;
        drive       = (state_nxt == ST_DRIVE);
        snap_nxt    = (p == '0 && slot == '0) ? bus.digits_in : snap;
        snap_dp_nxt = (p == '0 && slot == '0) ? bus.dp_in : snap_dp;
        sel         = snap_nxt[{slot_nxt, 2'b00} +: 4];
    end

`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz;

    always_comb begin
        logic run;
        run = 1'b1;
        lz  = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            run   = run && (snap_nxt[4*k +: 4] == 4'd0);
            lz[k] = run;
        end
        seg_nxt = lz[slot_nxt] ? SEG_N_OFF : dec;
    end
`else
    always_comb seg_nxt = dec;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p              <= '0;
            slot           <= '0;
            snap           <= '0;
            snap_dp        <= '0;
            bus.an_n       <= '1;
            bus.seg_n      <= SEG_N_OFF;
            bus.dp_n       <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            p              <= p_nxt;
            slot           <= slot_nxt;
            snap           <= snap_nxt;
            snap_dp        <= snap_dp_nxt;
            bus.an_n       <= drive ? ~(NUM_DIGITS'(1) << slot_nxt) : '1;
            bus.seg_n      <= drive ? seg_nxt : SEG_N_OFF;
            bus.dp_n       <= drive ? ~snap_dp_nxt[slot_nxt] : 1'b1;
            bus.frame_done <= (p_nxt == P_LAST) && (slot_nxt == S_LAST);
        end
    end
endmodule
